// File: rtl/mc_state_sequencer_pkg.sv
// Shared state codes, opcode constants and opcode-class type for the
// multi-cycle RV32I sequencer.
//   state_t     : 4-bit state encoding driven onto current_state
//   OP_*        : RV32I major opcodes (IR[6:0])
//   op_class_t  : one-hot instruction class from opcode_class_decode
package mc_state_sequencer_pkg;

  typedef enum logic [3:0] {
    IF_PC          = 4'd0,
    ID_REG_FETCH   = 4'd1,
    EX_ECALL       = 4'd2,
    EX_LD_SD       = 4'd3,
    MEM_READ       = 4'd4,
    WB_LD          = 4'd5,
    MEM_WRITE      = 4'd6,
    EX_R           = 4'd7,
    EX_IMM         = 4'd8,
    WB_R_I         = 4'd9,
    EX_BRANCH_COND = 4'd10,
    EX_WB_JAL      = 4'd11,
    EX_WB_JALR     = 4'd12,
    HALT           = 4'd13
  } state_t;

  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_ARITH     = 7'b0110011;
  localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_ECALL     = 7'b1110011;

  typedef struct packed {
    logic ld;
    logic sd;
    logic r;
    logic imm;
    logic br;
    logic jal;
    logic jalr;
    logic ecall;
    logic illegal;
  } op_class_t;

endpackage

// File: rtl/mc_state_sequencer_opcode_class_decode.sv
// opcode_class_decode: combinational map of IR[6:0] to a one-hot class.
//   op  : opcode field
//   cls : one-hot {ld, sd, r, imm, br, jal, jalr, ecall, illegal}
module opcode_class_decode
  import mc_state_sequencer_pkg::*;
(
  input  logic [6:0] op,
  output op_class_t  cls
);

  always_comb begin
    cls = '0;
    case (op)
      OP_LOAD:      cls.ld      = 1'b1;
      OP_STORE:     cls.sd      = 1'b1;
      OP_ARITH:     cls.r       = 1'b1;
      OP_ARITH_IMM: cls.imm     = 1'b1;
      OP_BRANCH:    cls.br      = 1'b1;
      OP_JAL:       cls.jal     = 1'b1;
      OP_JALR:      cls.jalr    = 1'b1;
      OP_ECALL:     cls.ecall   = 1'b1;
      default:      cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_state_sequencer.sv
// mc_state_sequencer: next-state engine of the multi-cycle RV32I core.
// Owns the state register, latches halt on ECALL, counts retirements.
// Ports:
//   clk, reset_n (async active-low)
//   part_of_inst[6:0] : opcode from IR
//   halt_req          : ECALL halt condition, sampled in EX_ECALL
//   mem_ready         : memory done strobe (only with MEM_READY_WAIT_EN)
//   current_state[3:0], is_halted, num_inst[CNT_WIDTH-1:0], illegal_inst
// Build option: define MEM_READY_WAIT_EN to make IF_PC/MEM_READ/MEM_WRITE
// wait for mem_ready; otherwise those states last one cycle.
module mc_state_sequencer
  import mc_state_sequencer_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [6:0]           part_of_inst,
  input  logic                 halt_req,
  input  logic                 mem_ready,
  output logic [3:0]           current_state,
  output logic                 is_halted,
  output logic [CNT_WIDTH-1:0] num_inst,
  output logic                 illegal_inst
);

  state_t    state_q, state_d;
  op_class_t cls;
  logic      retire;
  logic      halt_set;
  logic      mem_go;

`ifdef MEM_READY_WAIT_EN
  assign mem_go = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_go = 1'b1;
`endif

  opcode_class_decode u_dec (
    .op  (part_of_inst),
    .cls (cls)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IF_PC;
      is_halted <= 1'b0;
      num_inst  <= '0;
    end else begin
      state_q <= state_d;
      if (halt_set) is_halted <= 1'b1;
      if (retire)   num_inst  <= num_inst + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    retire   = 1'b0;
    halt_set = 1'b0;
    case (state_q)
      IF_PC:        if (mem_go) state_d = ID_REG_FETCH;
      ID_REG_FETCH: begin
        if (cls.ld || cls.sd) state_d = EX_LD_SD;
        else if (cls.r)       state_d = EX_R;
        else if (cls.imm)     state_d = EX_IMM;
        else if (cls.br)      state_d = EX_BRANCH_COND;
        else if (cls.jal)     state_d = EX_WB_JAL;
        else if (cls.jalr)    state_d = EX_WB_JALR;
        else if (cls.ecall)   state_d = EX_ECALL;
        else                  state_d = IF_PC;
      end
      // Opcode is held stable, so the class vector still splits load/store.
      EX_LD_SD: begin
        if (cls.ld)      state_d = MEM_READ;
        else if (cls.sd) state_d = MEM_WRITE;
        else             state_d = IF_PC;
      end
      MEM_READ:     if (mem_go) state_d = WB_LD;
      MEM_WRITE: begin
        if (mem_go) begin
          state_d = IF_PC;
          retire  = 1'b1;
        end
      end
      EX_R, EX_IMM: state_d = WB_R_I;
      WB_LD, WB_R_I, EX_BRANCH_COND, EX_WB_JAL, EX_WB_JALR: begin
        state_d = IF_PC;
        retire  = 1'b1;
      end
      // Halting ECALL is still counted as retired.
      EX_ECALL: begin
        retire = 1'b1;
        if (halt_req) begin
          state_d  = HALT;
          halt_set = 1'b1;
        end else begin
          state_d = IF_PC;
        end
      end
      HALT:         state_d = HALT;
      default:      state_d = IF_PC;
    endcase
  end

  assign current_state = state_q;
  assign illegal_inst  = (state_q == ID_REG_FETCH) && cls.illegal;

endmodule

// File: tb/tb_mc_state_sequencer.sv
module tb_mc_state_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [6:0]  part_of_inst;
  logic        halt_req;
  logic        mem_ready;
  logic [3:0]  current_state;
  logic        is_halted;
  logic [31:0] num_inst;
  logic        illegal_inst;

  int errors = 0;
  int checks = 0;
  int exp_num = 0;

  mc_state_sequencer #(.CNT_WIDTH(32)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .part_of_inst  (part_of_inst),
    .halt_req      (halt_req),
    .mem_ready     (mem_ready),
    .current_state (current_state),
    .is_halted     (is_halted),
    .num_inst      (num_inst),
    .illegal_inst  (illegal_inst)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; part_of_inst = 7'b0110011; halt_req = 1'b0; mem_ready = 1'b1;
    tick(); tick();
    checks++; if (current_state !== 4'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", current_state); end
    checks++; if (is_halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", is_halted); end
    checks++; if (num_inst !== 32'd0) begin errors++; $display("FAIL reset_num got=%0d exp=0", num_inst); end
    checks++; if (illegal_inst !== 1'b0) begin errors++; $display("FAIL reset_illegal got=%b exp=0", illegal_inst); end
    reset_n = 1'b1;
    exp_num = 0;
  endtask

  task automatic test_arith();
    logic [3:0] exp_seq [4] = '{4'd1, 4'd7, 4'd9, 4'd0};
    part_of_inst = 7'b0110011;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (current_state !== exp_seq[i]) begin errors++; $display("FAIL arith_state[%0d] got=%0d exp=%0d", i, current_state, exp_seq[i]); end
      if (i == 2) begin
        checks++; if (num_inst !== 32'(exp_num)) begin errors++; $display("FAIL arith_num_before got=%0d exp=%0d", num_inst, exp_num); end
      end
    end
    exp_num++;
    checks++; if (num_inst !== 32'(exp_num)) begin errors++; $display("FAIL arith_num got=%0d exp=%0d", num_inst, exp_num); end
  endtask

  task automatic test_back_to_back_ld_sd();
    logic [3:0] ld_seq [5] = '{4'd1, 4'd3, 4'd4, 4'd5, 4'd0};
    logic [3:0] sd_seq [4] = '{4'd1, 4'd3, 4'd6, 4'd0};
    part_of_inst = 7'b0000011;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (current_state !== ld_seq[i]) begin errors++; $display("FAIL load_state[%0d] got=%0d exp=%0d", i, current_state, ld_seq[i]); end
    end
    part_of_inst = 7'b0100011;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (current_state !== sd_seq[i]) begin errors++; $display("FAIL store_state[%0d] got=%0d exp=%0d", i, current_state, sd_seq[i]); end
    end
    exp_num += 2;
    checks++; if (num_inst !== 32'(exp_num)) begin errors++; $display("FAIL ldsd_num got=%0d exp=%0d", num_inst, exp_num); end
  endtask

  task automatic test_other_classes();
    logic [6:0] ops [4] = '{7'b1100011, 7'b1101111, 7'b1100111, 7'b0010011};
    logic [3:0] ex  [4] = '{4'd10, 4'd11, 4'd12, 4'd8};
    for (int k = 0; k < 4; k++) begin
      part_of_inst = ops[k];
      tick();
      checks++; if (current_state !== 4'd1) begin errors++; $display("FAIL cls%0d_id got=%0d exp=1", k, current_state); end
      tick();
      checks++; if (current_state !== ex[k]) begin errors++; $display("FAIL cls%0d_ex got=%0d exp=%0d", k, current_state, ex[k]); end
      if (k == 3) begin
        tick();
        checks++; if (current_state !== 4'd9) begin errors++; $display("FAIL imm_wb got=%0d exp=9", current_state); end
      end
      tick();
      exp_num++;
      checks++; if (current_state !== 4'd0) begin errors++; $display("FAIL cls%0d_if got=%0d exp=0", k, current_state); end
      checks++; if (num_inst !== 32'(exp_num)) begin errors++; $display("FAIL cls%0d_num got=%0d exp=%0d", k, num_inst, exp_num); end
    end
  endtask

  task automatic test_illegal();
    part_of_inst = 7'b0000000;
    checks++; if (illegal_inst !== 1'b0) begin errors++; $display("FAIL illegal_pre got=%b exp=0", illegal_inst); end
    tick();
    checks++; if (current_state !== 4'd1) begin errors++; $display("FAIL illegal_id got=%0d exp=1", current_state); end
    checks++; if (illegal_inst !== 1'b1) begin errors++; $display("FAIL illegal_pulse got=%b exp=1", illegal_inst); end
    tick();
    checks++; if (current_state !== 4'd0) begin errors++; $display("FAIL illegal_if got=%0d exp=0", current_state); end
    checks++; if (illegal_inst !== 1'b0) begin errors++; $display("FAIL illegal_post got=%b exp=0", illegal_inst); end
    checks++; if (num_inst !== 32'(exp_num)) begin errors++; $display("FAIL illegal_num got=%0d exp=%0d", num_inst, exp_num); end
  endtask

  task automatic test_ecall();
    logic [3:0] s0 [3] = '{4'd1, 4'd2, 4'd0};
    logic [3:0] s1 [3] = '{4'd1, 4'd2, 4'd13};
    part_of_inst = 7'b1110011;
    halt_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (current_state !== s0[i]) begin errors++; $display("FAIL ecall0_state[%0d] got=%0d exp=%0d", i, current_state, s0[i]); end
    end
    exp_num++;
    checks++; if (num_inst !== 32'(exp_num)) begin errors++; $display("FAIL ecall0_num got=%0d exp=%0d", num_inst, exp_num); end
    checks++; if (is_halted !== 1'b0) begin errors++; $display("FAIL ecall0_halted got=%b exp=0", is_halted); end
    halt_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (current_state !== s1[i]) begin errors++; $display("FAIL ecall1_state[%0d] got=%0d exp=%0d", i, current_state, s1[i]); end
    end
    exp_num++;
    checks++; if (is_halted !== 1'b1) begin errors++; $display("FAIL ecall1_halted got=%b exp=1", is_halted); end
    checks++; if (num_inst !== 32'(exp_num)) begin errors++; $display("FAIL ecall1_num got=%0d exp=%0d", num_inst, exp_num); end
    halt_req = 1'b0;
    part_of_inst = 7'b0110011;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if (current_state !== 4'd13) begin errors++; $display("FAIL halt_hold[%0d] got=%0d exp=13", i, current_state); end
    end
    checks++; if (num_inst !== 32'(exp_num)) begin errors++; $display("FAIL halt_num got=%0d exp=%0d", num_inst, exp_num); end
    checks++; if (is_halted !== 1'b1) begin errors++; $display("FAIL halt_sticky got=%b exp=1", is_halted); end
  endtask

  task automatic test_async_reset();
    // Leave HALT via a reset, retire one ARITH so the counter is nonzero.
    reset_n = 1'b0; #2; reset_n = 1'b1;
    checks++; if (current_state !== 4'd0) begin errors++; $display("FAIL halt_exit got=%0d exp=0", current_state); end
    part_of_inst = 7'b0110011;
    tick(); tick(); tick(); tick();
    checks++; if (num_inst !== 32'd1) begin errors++; $display("FAIL arst_pre_num got=%0d exp=1", num_inst); end
    part_of_inst = 7'b0000011;
    tick(); tick(); tick();
    checks++; if (current_state !== 4'd4) begin errors++; $display("FAIL arst_memread got=%0d exp=4", current_state); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (current_state !== 4'd0) begin errors++; $display("FAIL arst_state got=%0d exp=0", current_state); end
    checks++; if (num_inst !== 32'd0) begin errors++; $display("FAIL arst_num got=%0d exp=0", num_inst); end
    checks++; if (is_halted !== 1'b0) begin errors++; $display("FAIL arst_halted got=%b exp=0", is_halted); end
    tick();
    reset_n = 1'b1;
    exp_num = 0;
  endtask

`ifdef MEM_READY_WAIT_EN
  task automatic test_mem_wait();
    part_of_inst = 7'b0000011;
    mem_ready = 1'b1;
    tick(); tick(); tick();
    checks++; if (current_state !== 4'd4) begin errors++; $display("FAIL wait_memread got=%0d exp=4", current_state); end
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (current_state !== 4'd4) begin errors++; $display("FAIL wait_hold[%0d] got=%0d exp=4", i, current_state); end
    end
    mem_ready = 1'b1;
    tick();
    checks++; if (current_state !== 4'd5) begin errors++; $display("FAIL wait_wb got=%0d exp=5", current_state); end
    tick();
    checks++; if (current_state !== 4'd0) begin errors++; $display("FAIL wait_if got=%0d exp=0", current_state); end
  endtask
`endif

  initial begin
    test_reset();
    test_arith();
    test_back_to_back_ld_sd();
    test_other_classes();
    test_illegal();
    test_ecall();
    test_async_reset();
`ifdef MEM_READY_WAIT_EN
    test_mem_wait();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_state_sequencer.md
Name: mc_state_sequencer

Overview:
- Sequential next-state engine for the multi-cycle RV32I core; owns the `current_state` register and feeds it to the combinational control unit each cycle.
- Walks every instruction through its fetch/decode/execute/memory/writeback phases.
- Latches halt on ECALL and counts retired instructions.
- Sits between the instruction register (opcode source) and the control unit (state consumer).

Parameters:
- CNT_WIDTH, 32, width of retired-instruction counter `num_inst`.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- part_of_inst  in  7  opcode field IR[6:0]; stable from ID_REG_FETCH until the instruction retires.
- halt_req  in  1  ECALL halt condition (x17==10); sampled only in EX_ECALL.
- mem_ready  in  1  memory completion strobe; used only when MEM_READY_WAIT_EN is defined, ignored otherwise.
- current_state  out  4  present state code, driven straight from the state register.
- is_halted  out  1  sticky halt flag.
- num_inst  out  CNT_WIDTH  count of retired instructions.
- illegal_inst  out  1  one-cycle pulse on an undecodable opcode.

Behaviour:
- Reset: asynchronous, active-low.
  - While reset_n=0: current_state=IF_PC, is_halted=0, num_inst=0, illegal_inst=0.
  - Reset asserted mid-instruction aborts it immediately; no retire is counted.
- State codes (4-bit):
  - IF_PC=0, ID_REG_FETCH=1, EX_ECALL=2, EX_LD_SD=3, MEM_READ=4, WB_LD=5, MEM_WRITE=6.
  - EX_R=7, EX_IMM=8, WB_R_I=9, EX_BRANCH_COND=10, EX_WB_JAL=11, EX_WB_JALR=12, HALT=13.
  - Codes 14 and 15 are unused; if ever reached, next state is IF_PC.
- Transitions, one per clock edge unless stated:
  - IF_PC -> ID_REG_FETCH.
  - ID_REG_FETCH decodes the opcode:
    - LOAD 0000011 or STORE 0100011 -> EX_LD_SD.
    - ARITH 0110011 -> EX_R.
    - ARITH_IMM 0010011 -> EX_IMM.
    - BRANCH 1100011 -> EX_BRANCH_COND.
    - JAL 1101111 -> EX_WB_JAL.
    - JALR 1100111 -> EX_WB_JALR.
    - ECALL 1110011 -> EX_ECALL.
    - Any other opcode -> IF_PC, with illegal_inst=1 for that one cycle.
  - EX_LD_SD -> MEM_READ if LOAD, MEM_WRITE if STORE.
  - MEM_READ -> WB_LD -> IF_PC.
  - MEM_WRITE -> IF_PC.
  - EX_R and EX_IMM -> WB_R_I -> IF_PC.
  - EX_BRANCH_COND, EX_WB_JAL, EX_WB_JALR -> IF_PC.
  - EX_ECALL:
    - halt_req=1 -> HALT; is_halted set on the same edge.
    - halt_req=0 -> IF_PC.
  - HALT is absorbing; only reset leaves it.
- Latency in cycles:
  - R-type, I-type ALU, store: 4.
  - Load: 5.
  - Branch, JAL, JALR, non-halting ECALL: 3.
- Retire counting:
  - num_inst increments by 1 on every edge that moves a final state to IF_PC.
  - Final states: WB_LD, MEM_WRITE, WB_R_I, EX_BRANCH_COND, EX_WB_JAL, EX_WB_JALR, and EX_ECALL when halt_req=0.
  - EX_ECALL -> HALT also increments the counter, so the halting ECALL is counted.
  - Illegal opcodes do not increment.
  - The counter wraps modulo 2^CNT_WIDTH silently.
- All outputs are registered or pure decode of the state register; there is no combinational path from part_of_inst to current_state.
  - Exception: illegal_inst is decoded from current_state==ID_REG_FETCH together with part_of_inst.

Optional Feature:
- MEM_READY_WAIT_EN defined:
  - IF_PC, MEM_READ and MEM_WRITE hold their state while mem_ready=0.
  - They advance on the first cycle with mem_ready=1.
  - Retire from MEM_WRITE occurs only on that advancing edge.
- MEM_READY_WAIT_EN undefined:
  - mem_ready is ignored; these states last exactly one cycle.

Decomposition:
- State codes and opcode constants live in the shared state_codes.v / opcodes.v headers; HALT=13 is added to state_codes.v.
- One natural sub-module, `opcode_class_decode`: combinational map of part_of_inst to a one-hot class vector {ld, sd, r, imm, br, jal, jalr, ecall, illegal}.
- The sequencer uses that class vector for both ID_REG_FETCH dispatch and the EX_LD_SD load/store split.

Test Plan:
- Reset and ARITH: release reset_n with part_of_inst=0110011 -> states 0,1,7,9,0; num_inst=1 after the 4th edge.
- LOAD then STORE back-to-back:
  - LOAD (0000011) -> 0,1,3,4,5,0.
  - STORE (0100011) -> 0,1,3,6,0.
  - num_inst=2 after 9 edges.
- ECALL:
  - With halt_req=0 -> 0,1,2,0 and num_inst+1.
  - Repeat with halt_req=1 -> enters 13; is_halted=1; state stays 13 for 20 further cycles.
- Illegal opcode 0000000 -> 0,1,0; illegal_inst high exactly 1 cycle; num_inst unchanged.
- Async reset: assert reset_n=0 mid-cycle while in MEM_READ -> current_state=0 before the next clock edge; num_inst=0; is_halted=0.
- With MEM_READY_WAIT_EN and a LOAD: hold mem_ready=0 for 3 cycles in MEM_READ -> state remains 4 for those cycles, then goes to 5 on the first edge with mem_ready=1.
